// File: rtl/tetris_input_ctrl_if.sv
// rtl/tetris_input_ctrl_if.sv - core state/command type and the button/core-side bundle of the input controller
package tetris_pkg;
    typedef enum logic [3:0] {
        NONE       = 4'd0,
        INIT       = 4'd1,
        WAIT       = 4'd2,
        END        = 4'd3,
        HOLD       = 4'd4,
        DROP       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        LEFT       = 4'd8,
        RIGHT      = 4'd9,
        DOWN       = 4'd10,
        BAR        = 4'd11,
        FALL       = 4'd12,
        CLEAR      = 4'd13
    } state_type;
endpackage

interface tetris_input_ctrl_if;
    import tetris_pkg::*;

    logic        btn_left;
    logic        btn_right;
    logic        btn_down;
    logic        btn_drop;
    logic        btn_rot;
    logic        btn_rot_rev;
    logic        btn_hold;
    logic [2:0]  speed;
    logic [31:0] rng;
    state_type   core_state;
    state_type   ctrl;
    logic [9:0]  bar_mask;

    modport master (
        input  btn_left, btn_right, btn_down, btn_drop, btn_rot, btn_rot_rev, btn_hold,
        input  speed, rng, core_state,
        output ctrl, bar_mask
    );

    modport slave (
        output btn_left, btn_right, btn_down, btn_drop, btn_rot, btn_rot_rev, btn_hold,
        output speed, rng, core_state,
        input  ctrl, bar_mask
    );
endinterface

// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - turns buttons, gravity and garbage timers into one-cycle core commands
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned GRAVITY_TICKS = 50_000_000,
    parameter int unsigned DAS_TICKS     = 10_000_000,
    parameter int unsigned ARR_TICKS     = 2_500_000,
    parameter int unsigned BAR_TICKS     = 500_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    tetris_input_ctrl_if.master  bus
);

    // Pending-bit index doubles as issue priority: lower index wins.
    localparam int P_HOLD = 0;
    localparam int P_DROP = 1;
    localparam int P_DOWN = 6;
    localparam int P_BAR  = 7;

    localparam logic [31:0] GRAV_C = 32'(GRAVITY_TICKS);
    localparam logic [31:0] DAS_C  = 32'(DAS_TICKS);
    localparam logic [31:0] ARR_M1 = 32'(ARR_TICKS) - 32'd1;
    localparam logic [31:0] BAR_C  = 32'(BAR_TICKS);

    logic [6:0]  btn;
    logic [6:0]  btn_prev;
    logic [6:0]  press;
    logic [7:0]  pend;
    logic [7:0]  pend_set;
    logic [7:0]  pend_next;
    logic [7:0]  issue;
    logic [2:0]  rep_btn;
    logic [2:0]  rep_on;
    logic [2:0]  rep_fire;
    logic [31:0] rep_cnt [3];
    logic [31:0] grav_cnt;
    logic [31:0] grav_inc;
    logic [31:0] grav_period;
    logic [31:0] bar_cnt;
    logic [31:0] bar_inc;
    logic        idle_state;
    logic        wait_state;
    logic        run;
    logic        grav_fire;
    logic        bar_fire;
    logic        bar_latch;
    logic        bar_keep;
    logic [3:0]  hole;
    logic [9:0]  hole_mask;
    logic [9:0]  bar_mask_q;
    state_type   ctrl_q;
    state_type   ctrl_next;
    logic        unused_rng;

    assign unused_rng = ^bus.rng[31:4];

    assign btn = {bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_rot_rev,
                  bus.btn_rot, bus.btn_drop, bus.btn_hold};
    assign press   = btn & ~btn_prev;
    assign rep_btn = btn[6:4];

    assign idle_state = (bus.core_state == INIT) || (bus.core_state == END);
    assign wait_state = (bus.core_state == WAIT);
    assign run        = !idle_state;

    always_comb begin
        grav_period = GRAV_C >> bus.speed;
        if (grav_period == 32'd0) begin
            grav_period = 32'd1;
        end
    end

    assign grav_inc  = grav_cnt + 32'd1;
    assign grav_fire = run && (grav_inc >= grav_period - 32'd1);
    assign bar_inc   = bar_cnt + 32'd1;
    assign bar_fire  = run && (BAR_C != 32'd0) && (bar_inc >= BAR_C - 32'd1);
    assign bar_latch = bar_fire && !pend[P_BAR];

    // Repeat only starts from a real press, so a button held through reset stays silent.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 3; i++) begin
            rep_fire[i] = rep_btn[i] && (rep_on[i] ? (rep_cnt[i] == ARR_M1) : (rep_cnt[i] == DAS_C));
        end
    end

    always_comb begin
        issue = '0;
        if (ctrl_q == NONE) begin
            if (wait_state) begin
                for (int i = 7; i >= 0; i--) begin
                    if (pend[i]) begin
                        issue = 8'd1 << i;
                    end
                end
            end else if (idle_state && pend[P_DROP]) begin
                issue[P_DROP] = 1'b1;
            end
        end
    end

    always_comb begin
        case (issue)
            8'b0000_0001: ctrl_next = HOLD;
            8'b0000_0010: ctrl_next = DROP;
            8'b0000_0100: ctrl_next = ROTATE;
            8'b0000_1000: ctrl_next = ROTATE_REV;
            8'b0001_0000: ctrl_next = LEFT;
            8'b0010_0000: ctrl_next = RIGHT;
            8'b0100_0000: ctrl_next = DOWN;
            8'b1000_0000: ctrl_next = BAR;
            default:      ctrl_next = NONE;
        endcase
    end

    // New sets are OR-ed after the issue clear, so a fresh event on the issuing edge survives.
    assign pend_set = {bar_fire,
                       press | {rep_fire, 4'b0000} | {grav_fire, 6'b00_0000}};

    always_comb begin
        pend_next = '0;
        if (idle_state) begin
            pend_next[P_DROP] = (pend[P_DROP] & ~issue[P_DROP]) | press[P_DROP];
        end else begin
            pend_next = (pend & ~issue) | pend_set;
        end
    end

    assign hole      = (bus.rng[3:0] >= 4'd10) ? (bus.rng[3:0] - 4'd10) : bus.rng[3:0];
    assign hole_mask = 10'd1 << hole;
    // Mask lives while BAR is pending, on its issue edge, and through the pulse cycle itself.
    assign bar_keep  = pend_next[P_BAR] | issue[P_BAR] | (ctrl_q == BAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev   <= '1;
            pend       <= '0;
            ctrl_q     <= NONE;
            bar_mask_q <= '0;
            grav_cnt   <= '0;
            bar_cnt    <= '0;
            rep_on     <= '0;
            for (int i = 0; i < 3; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            btn_prev <= btn;
            pend     <= pend_next;
            ctrl_q   <= ctrl_next;

            if (!run || grav_fire || issue[P_DOWN] || issue[P_DROP]) begin
                grav_cnt <= '0;
            end else begin
                grav_cnt <= grav_inc;
            end

            if (!run || (BAR_C == 32'd0) || bar_fire) begin
                bar_cnt <= '0;
            end else begin
                bar_cnt <= bar_inc;
            end

            if (bar_latch) begin
                bar_mask_q <= hole_mask;
            end else if (!bar_keep) begin
                bar_mask_q <= '0;
            end

            for (int i = 0; i < 3; i++) begin
                if (!rep_btn[i]) begin
                    rep_cnt[i] <= '0;
                    rep_on[i]  <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i] <= '0;
                    rep_on[i]  <= 1'b1;
                end else if (press[4 + i] || rep_on[i] || (rep_cnt[i] != 32'd0)) begin
                    rep_cnt[i] <= rep_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign bus.ctrl     = ctrl_q;
    assign bus.bar_mask = bar_mask_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb/tb_tetris_input_ctrl.sv - scenario bench for tetris_input_ctrl with small-parameter timing
module tb_tetris_input_ctrl;
    import tetris_pkg::*;

    localparam int GT = 16;
    localparam int DT = 6;
    localparam int AT = 3;
    localparam int BT = 40;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    state_type cmd_tab [7] = '{HOLD, DROP, ROTATE, ROTATE_REV, LEFT, RIGHT, DOWN};

    always #5 clk = ~clk;

    tetris_input_ctrl_if bus ();

    tetris_input_ctrl #(
        .GRAVITY_TICKS (GT),
        .DAS_TICKS     (DT),
        .ARR_TICKS     (AT),
        .BAR_TICKS     (BT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: bus.btn_hold    = v;
            1: bus.btn_drop    = v;
            2: bus.btn_rot     = v;
            3: bus.btn_rot_rev = v;
            4: bus.btn_left    = v;
            5: bus.btn_right   = v;
            default: bus.btn_down = v;
        endcase
    endtask

    task automatic set_all(input logic [6:0] m);
        for (int i = 0; i < 7; i++) set_btn(i, m[i]);
    endtask

    // END clears pending work and holds both timers at zero.
    task automatic quiesce();
        reset = 1'b0;
        bus.core_state = END;
        bus.speed = 3'd0;
        set_all(7'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.core_state = WAIT;
        bus.speed = 3'd0;
        bus.rng = 32'd0;
        set_all(7'd0);
        bus.btn_left = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.ctrl !== NONE || bus.bar_mask !== 10'd0) begin
            bad++;
            $display("FAIL reset_state ctrl=%0d mask=%b expected ctrl=%0d mask=0", bus.ctrl, bus.bar_mask, NONE);
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) bus.btn_left = 1'b0;
            tick();
            total++;
            if (bus.ctrl !== NONE) begin
                bad++;
                $display("FAIL reset_held k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, NONE);
            end
        end
        bus.btn_left = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            state_type exp;
            tick();
            exp = (k == 2) ? LEFT : NONE;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL reset_repress k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
        bus.btn_left = 1'b0;
    endtask

    task automatic test_hold_left();
        state_type exp_seq [7] = '{NONE, HOLD, NONE, NONE, NONE, LEFT, NONE};
        quiesce();
        bus.core_state = WAIT;
        bus.btn_hold = 1'b1;
        bus.btn_left = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) set_all(7'd0);
            if (k == 2) bus.core_state = HOLD;
            if (k == 5) bus.core_state = WAIT;
            total++;
            if (bus.ctrl !== exp_seq[k-1]) begin
                bad++;
                $display("FAIL hold_left k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp_seq[k-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 5; it++) begin
            logic [6:0] m;
            m = 7'($urandom_range(1, 127));
            quiesce();
            bus.core_state = WAIT;
            set_all(m);
            tick();
            set_all(7'd0);
            total++;
            if (bus.ctrl !== NONE) begin
                bad++;
                $display("FAIL b2b_first m=%b ctrl=%0d expected=%0d", m, bus.ctrl, NONE);
            end
            for (int j = 0; j < 7; j++) begin
                if (m[j]) begin
                    tick();
                    total++;
                    if (bus.ctrl !== cmd_tab[j]) begin
                        bad++;
                        $display("FAIL b2b_cmd m=%b j=%0d ctrl=%0d expected=%0d", m, j, bus.ctrl, cmd_tab[j]);
                    end
                    tick();
                    total++;
                    if (bus.ctrl !== NONE) begin
                        bad++;
                        $display("FAIL b2b_gap m=%b j=%0d ctrl=%0d expected=%0d", m, j, bus.ctrl, NONE);
                    end
                end
            end
        end
    endtask

    task automatic test_autorepeat(input int idx, input int h);
        int seen;
        int want;
        seen = 0;
        quiesce();
        bus.core_state = WAIT;
        set_btn(idx, 1'b1);
        for (int k = 1; k <= h + 2; k++) begin
            int s;
            state_type exp;
            tick();
            if (k == h) set_btn(idx, 1'b0);
            s = k - 1;
            exp = (s >= 1 && s <= h && (s == 1 || (s >= 1 + DT && (s - 1 - DT) % AT == 0))) ? cmd_tab[idx] : NONE;
            if (bus.ctrl == cmd_tab[idx]) seen++;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL autorepeat btn=%0d h=%0d k=%0d ctrl=%0d expected=%0d", idx, h, k, bus.ctrl, exp);
            end
        end
        want = 1 + ((h >= 1 + DT) ? 1 + (h - 1 - DT) / AT : 0);
        total++;
        if (seen != want) begin
            bad++;
            $display("FAIL autorepeat_count btn=%0d h=%0d pulses=%0d expected=%0d", idx, h, seen, want);
        end
    endtask

    task automatic test_gravity(input int spd, input int n);
        int p;
        quiesce();
        bus.core_state = WAIT;
        bus.speed = 3'(spd);
        p = GT >> spd;
        if (p < 2) p = 2;
        for (int k = 1; k <= n; k++) begin
            state_type exp;
            tick();
            exp = (k % p == 0) ? DOWN : NONE;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL gravity speed=%0d k=%0d ctrl=%0d expected=%0d", spd, k, bus.ctrl, exp);
            end
        end
    endtask

    task automatic test_drop_gravity();
        quiesce();
        bus.core_state = WAIT;
        for (int k = 1; k <= 30; k++) begin
            state_type exp;
            if (k == 9) bus.btn_drop = 1'b1;
            if (k == 10) bus.btn_drop = 1'b0;
            tick();
            exp = (k == 10) ? DROP : (k == 26) ? DOWN : NONE;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL drop_gravity k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
    endtask

    task automatic test_speed_change();
        quiesce();
        bus.core_state = WAIT;
        for (int k = 1; k <= 12; k++) begin
            state_type exp;
            if (k == 11) bus.speed = 3'd2;
            tick();
            exp = (k == 12) ? DOWN : NONE;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL speed_change k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
    endtask

    task automatic test_bar(input logic force13);
        logic [31:0] rv;
        logic [9:0]  mexp;
        int          h;
        h = 0;
        quiesce();
        bus.core_state = WAIT;
        for (int k = 1; k <= 43; k++) begin
            state_type exp;
            rv = $urandom;
            if (k == 39) begin
                if (force13) rv[3:0] = 4'd13;
                h = (rv[3:0] >= 10) ? int'(rv[3:0]) - 10 : int'(rv[3:0]);
            end
            bus.rng = rv;
            tick();
            mexp = (k >= 39 && k <= 41) ? (10'd1 << h) : 10'd0;
            exp = (k == 16 || k == 32) ? DOWN : (k == 40) ? BAR : NONE;
            total++;
            if (bus.bar_mask !== mexp) begin
                bad++;
                $display("FAIL bar_mask k=%0d mask=%b expected=%b", k, bus.bar_mask, mexp);
            end
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL bar_ctrl k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
    endtask

    task automatic test_bar_pending();
        logic [31:0] rv;
        logic [9:0]  m;
        state_type   cseq [5] = '{DOWN, NONE, BAR, NONE, NONE};
        m = 10'd0;
        quiesce();
        bus.core_state = FALL;
        for (int k = 1; k <= 85; k++) begin
            logic [9:0] mexp;
            state_type  exp;
            rv = $urandom;
            bus.rng = rv;
            if (k == 39) m = 10'd1 << ((rv[3:0] >= 10) ? int'(rv[3:0]) - 10 : int'(rv[3:0]));
            if (k == 81) bus.core_state = WAIT;
            tick();
            mexp = (k >= 39 && k <= 84) ? m : 10'd0;
            exp  = (k >= 81) ? cseq[k-81] : NONE;
            total++;
            if (bus.bar_mask !== mexp) begin
                bad++;
                $display("FAIL bar_pending_mask k=%0d mask=%b expected=%b", k, bus.bar_mask, mexp);
            end
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL bar_pending_ctrl k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
    endtask

    task automatic test_end_reset();
        quiesce();
        bus.btn_left = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            state_type exp;
            if (k == 2) bus.btn_left = 1'b0;
            if (k == 5) bus.btn_drop = 1'b1;
            if (k == 6) bus.btn_drop = 1'b0;
            if (k == 8) bus.core_state = WAIT;
            tick();
            exp = (k == 6) ? DROP : NONE;
            total++;
            if (bus.ctrl !== exp) begin
                bad++;
                $display("FAIL end_state k=%0d ctrl=%0d expected=%0d", k, bus.ctrl, exp);
            end
        end
        quiesce();
        bus.core_state = FALL;
        bus.rng = 32'd5;
        bus.btn_left = 1'b1;
        tick();
        bus.btn_left = 1'b0;
        repeat (41) tick();
        total++;
        if (bus.bar_mask !== 10'b00_0010_0000) begin
            bad++;
            $display("FAIL pre_reset_mask mask=%b expected=%b", bus.bar_mask, 10'b00_0010_0000);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.core_state = WAIT;
        for (int k = 0; k <= 12; k++) begin
            total++;
            if (bus.ctrl !== NONE || bus.bar_mask !== 10'd0) begin
                bad++;
                $display("FAIL post_reset k=%0d ctrl=%0d mask=%b expected ctrl=%0d mask=0", k, bus.ctrl, bus.bar_mask, NONE);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hold_left();
        test_back_to_back();
        test_autorepeat(5, 13);
        test_autorepeat(6, 18);
        test_autorepeat(4, int'($urandom_range(1, 13)));
        test_autorepeat(6, int'($urandom_range(1, 24)));
        test_gravity(0, 36);
        test_gravity(2, 36);
        test_gravity(int'($urandom_range(0, 7)), 36);
        test_drop_gravity();
        test_speed_change();
        test_bar(1'b1);
        test_bar(1'b0);
        test_bar_pending();
        test_end_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
